// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and default vectors for the IF-stage PC generator.
package pc_pkg;

  typedef enum logic [1:0] {RUN, HOLD, PEND} pc_state_t;

  typedef enum logic [2:0] {
    SRC_SEQ, SRC_BR, SRC_JMP, SRC_ERET, SRC_EXC, SRC_PEND
  } redir_src_t;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Redirect requests in, fetch address and status out.
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              update_en, busy;
    logic              br_taken, jmp_valid, eret_req, exc_req;
    logic [ADDR_W-1:0] br_target, jmp_target, epc;
    logic [ADDR_W-1:0] pc_current, pc_plus, bad_addr;
    logic              redir_pending, addr_err;

    modport master (
        output update_en, busy, br_taken, br_target, jmp_valid, jmp_target,
               eret_req, epc, exc_req,
        input  pc_current, pc_plus, redir_pending, addr_err, bad_addr
    );

    modport slave (
        input  update_en, busy, br_taken, br_target, jmp_valid, jmp_target,
               eret_req, epc, exc_req,
        output pc_current, pc_plus, redir_pending, addr_err, bad_addr
    );
endinterface

// File: rtl/pc_fetch_unit_redirect_arb.sv
// Priority select of the next-PC source: exc > eret > jmp > br > pending > sequential.
import pc_pkg::*;

module pc_redirect_arb #(
    parameter int              ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] EXC_VEC = PC_EXC_VEC[ADDR_W-1:0]
) (
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic              jmp_valid,
    input  logic              br_taken,
    input  logic              pend_valid,
    input  logic [ADDR_W-1:0] epc,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] pend_target,
    input  logic [ADDR_W-1:0] pc_plus,
    output redir_src_t        src,
    output logic [ADDR_W-1:0] target
);
    always_comb begin
        src    = SRC_SEQ;
        target = pc_plus;
        if (exc_req) begin
            src    = SRC_EXC;
            target = EXC_VEC;
        end else if (eret_req) begin
            src    = SRC_ERET;
            target = epc;
        end else if (jmp_valid) begin
            src    = SRC_JMP;
            target = jmp_target;
        end else if (br_taken) begin
            src    = SRC_BR;
            target = br_target;
        end else if (pend_valid) begin
            src    = SRC_PEND;
            target = pend_target;
        end
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage PC register with stall handling and a one-deep redirect buffer.
// Optional misaligned-target trap is enabled by defining PC_ALIGN_CHECK_EN.
import pc_pkg::*;

module pc_fetch_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = PC_RESET_VEC[ADDR_W-1:0],
    parameter logic [ADDR_W-1:0] EXC_VEC    = PC_EXC_VEC[ADDR_W-1:0],
    parameter int                STEP       = 4,
    parameter int                ALIGN_BITS = 2
) (
    input  logic          clk,
    input  logic          reset,
    pc_fetch_unit_if.slave bus
);
    pc_state_t         state;
    redir_src_t        src;
    logic [ADDR_W-1:0] pc_q, pend_tgt, sel_tgt, bad_q;
    logic              err_q, stall, live, misalign;

    assign stall = !bus.update_en || bus.busy;
    assign live  = bus.eret_req || bus.jmp_valid || bus.br_taken;

    assign bus.pc_current    = pc_q;
    assign bus.pc_plus       = pc_q + ADDR_W'(STEP);
    assign bus.redir_pending = (state == PEND);
    assign bus.addr_err      = err_q;
    assign bus.bad_addr      = bad_q;

    pc_redirect_arb #(.ADDR_W(ADDR_W), .EXC_VEC(EXC_VEC)) u_arb (
        .exc_req    (bus.exc_req),
        .eret_req   (bus.eret_req),
        .jmp_valid  (bus.jmp_valid),
        .br_taken   (bus.br_taken),
        .pend_valid (state == PEND),
        .epc        (bus.epc),
        .jmp_target (bus.jmp_target),
        .br_target  (bus.br_target),
        .pend_target(pend_tgt),
        .pc_plus    (bus.pc_plus),
        .src        (src),
        .target     (sel_tgt)
    );

`ifdef PC_ALIGN_CHECK_EN
    // Checked at apply time only; sequential and exception vectors are trusted.
    assign misalign = (src inside {SRC_BR, SRC_JMP, SRC_ERET, SRC_PEND}) &&
                      (|sel_tgt[ALIGN_BITS-1:0]);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_VEC;
            pend_tgt <= '0;
            state    <= RUN;
            err_q    <= 1'b0;
            bad_q    <= '0;
        end else begin
            err_q <= 1'b0;
            if (bus.exc_req) begin
                pc_q  <= EXC_VEC;
                state <= RUN;
            end else if (stall) begin
                // Live redirect outranks pending in the arbiter, so newest wins.
                if (live) begin
                    pend_tgt <= sel_tgt;
                    state    <= PEND;
                end else if (state == RUN) begin
                    state <= HOLD;
                end
            end else begin
                state <= RUN;
                if (misalign) begin
                    pc_q  <= EXC_VEC;
                    err_q <= 1'b1;
                    bad_q <= sel_tgt;
                end else begin
                    pc_q <= sel_tgt;
                end
            end
        end
    end
endmodule
